ex_op_sequencer: RTL and testbench
==================================

Name: ex_op_sequencer

Overview:
EX-stage operation decoder and sequencer, successor to the combinational ALU-control decode.
- Decodes EXcntrl/funct3/funct7 into ALUOp, FPUOp and csr_immidiate, and registers the result.
- Tracks per-class multi-cycle latency (MUL, DIV/REM, FPU) with a valid/ready handshake; drives the ID/EX stall.
- Sits between the ID/EX pipeline register and the ALU/MDU/FPU datapath.

Parameters:
MUL_LAT, 3, cycles from accept to out_valid for MUL/MULH/MULHSU/MULHU (1..255)
DIV_LAT, 33, cycles for DIV/DIVU/REM/REMU (1..255)
FPU_LAT, 4, cycles for any FPU op (1..255)
FPU_OP_W, 3, FPUOp width (>=3)

Ports:
clock  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  ID/EX holds a valid instruction
in_ready  out  1  sequencer accepts this cycle
EXcntrl  in  4  EX control class
funct3  in  3  instruction funct3
funct7  in  7  instruction funct7
divisor_zero  in  1  rs2 operand == 0 (used only with optional feature)
flush  in  1  synchronous pipeline flush
out_valid  out  1  decoded op complete, result valid
out_ready  in  1  EX/MEM accepts result
ALUOp  out  5  registered ALU operation
FPUOp  out  FPU_OP_W  registered FPU operation
csr_immidiate  out  1  registered CSR-immediate select
stall  out  1  in_valid && !in_ready

Behaviour:
- Reset (async, reset==0): state=IDLE, cnt=0, out_valid=0, ALUOp=`ADD, FPUOp=0, csr_immidiate=0.
- Decode:
  - ALU_R and ALU_I_COMP use the standard RV32IM mapping; any unlisted combination gives `ADD.
  - I-type shift right: funct7==`FUNCT7_SUB → `SRA, else `SRL.
  - BRANCH: BLTU/BGEU → `SUBU, all others `SUB.
  - LUI → `LUI; AUIPC → `AUIPC; LOAD_STORE and J → `ADD.
  - CSR: RW/RS/RC → `ADD/`OR/`CLEAR; the I variants give the same ALUOp with csr_immidiate=1.
  - FPU: ALUOp=`ADD; FPUOp from funct7[6:2]: 00000 `FADD, 00001 `FSUB, 00010 `FMUL, 00011 `FDIV, 01011 `FSQRT, others `FADD.
- Latency L per accepted op:
  - MUL group: MUL_LAT.
  - DIV/REM group: DIV_LAT.
  - FPU class: FPU_LAT.
  - All else: 1.
- Accept occurs when in_valid && in_ready. Decode outputs are captured on accept and held stable until the next accept, flush or reset.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- FSM:
  - IDLE: accept with L==1 → DONE; with L>1 → BUSY, cnt=L-1.
  - BUSY: cnt decrements each cycle; when cnt==1 → DONE.
  - DONE: out_valid=1. With out_ready: accept pending input (back-to-back, no bubble) or go to IDLE. Without out_ready: hold all outputs.
- out_valid rises exactly L cycles after the accept edge.
- flush has priority over everything: next state IDLE, out_valid=0, cnt=0, no accept that cycle. ALUOp/FPUOp/csr_immidiate retain their values.
- Reset deasserted mid-operation: the FSM restarts from IDLE; the aborted op is never reported.

Optional Feature:
EX_DIVZERO_FAST_EN
- Defined: a DIV/DIVU/REM/REMU accepted with divisor_zero=1 uses L=1.
- Undefined: divisor_zero is ignored and the op always takes DIV_LAT.

Decomposition:
- Add to the shared constants include:
  - new FPU codes `FSUB, `FMUL, `FDIV, `FSQRT (FPU_OP_W wide);
  - the FSM state encodings.
- Existing ALUOp, FUNCT3/FUNCT7 and EXcntrl constants are reused.
- One combinational sub-module, ex_op_decode, produces ALUOp, FPUOp, csr_immidiate and a 2-bit latency class. ex_op_sequencer holds the FSM, counter and registers.

Test Plan:
- ALU_R funct7=0000000 funct3=000, in_valid=1, out_ready=1 → next cycle out_valid=1, ALUOp=`ADD; a second ADD is accepted in that same cycle, so there are no bubbles.
- ALU_R funct7=0000001 funct3=100 (DIV), DIV_LAT=33 → stall=1 for the following instruction; out_valid exactly 33 cycles after accept; ALUOp=`DIV throughout.
- FPU funct7=0001000 (FMUL), FPU_LAT=4 → FPUOp=`FMUL, out_valid after 4 cycles. With out_ready=0 for 3 cycles, outputs hold and in_ready=0.
- MUL in BUSY with cnt=1, flush=1 → next cycle IDLE, out_valid=0; a new instruction is accepted the cycle after.
- DIV with divisor_zero=1 → out_valid after 1 cycle when EX_DIVZERO_FAST_EN is defined, after 33 cycles when it is not.
- ALU_I_COMP funct3=101 with funct7=0100000 → `SRA; with 0000000 → `SRL. CSRRCI → `CLEAR with csr_immidiate=1. Async reset mid-DIV → all outputs at reset values immediately.

Source files
------------

// File: rtl/ex_op_sequencer_pkg.sv
// Shared EX-stage constants: control classes, funct codes, ALU/FPU op codes,
// sequencer state and latency-class encodings.
package ex_op_sequencer_pkg;

  localparam logic [3:0] EX_ALU_R      = 4'd0;
  localparam logic [3:0] EX_ALU_I_COMP = 4'd1;
  localparam logic [3:0] EX_BRANCH     = 4'd2;
  localparam logic [3:0] EX_LUI        = 4'd3;
  localparam logic [3:0] EX_AUIPC      = 4'd4;
  localparam logic [3:0] EX_LOAD_STORE = 4'd5;
  localparam logic [3:0] EX_J          = 4'd6;
  localparam logic [3:0] EX_CSR        = 4'd7;
  localparam logic [3:0] EX_FPU        = 4'd8;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_SUB    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_ADD    = 3'b000;
  localparam logic [2:0] FUNCT3_SLL    = 3'b001;
  localparam logic [2:0] FUNCT3_SLT    = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU   = 3'b011;
  localparam logic [2:0] FUNCT3_XOR    = 3'b100;
  localparam logic [2:0] FUNCT3_SR     = 3'b101;
  localparam logic [2:0] FUNCT3_OR     = 3'b110;
  localparam logic [2:0] FUNCT3_AND    = 3'b111;
  localparam logic [2:0] FUNCT3_BLTU   = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU   = 3'b111;
  localparam logic [2:0] FUNCT3_CSRRW  = 3'b001;
  localparam logic [2:0] FUNCT3_CSRRS  = 3'b010;
  localparam logic [2:0] FUNCT3_CSRRC  = 3'b011;
  localparam logic [2:0] FUNCT3_CSRRWI = 3'b101;
  localparam logic [2:0] FUNCT3_CSRRSI = 3'b110;
  localparam logic [2:0] FUNCT3_CSRRCI = 3'b111;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_SUBU   = 5'd10;
  localparam logic [4:0] ALU_LUI    = 5'd11;
  localparam logic [4:0] ALU_AUIPC  = 5'd12;
  localparam logic [4:0] ALU_CLEAR  = 5'd13;
  localparam logic [4:0] ALU_MUL    = 5'd14;
  localparam logic [4:0] ALU_MULH   = 5'd15;
  localparam logic [4:0] ALU_MULHSU = 5'd16;
  localparam logic [4:0] ALU_MULHU  = 5'd17;
  localparam logic [4:0] ALU_DIV    = 5'd18;
  localparam logic [4:0] ALU_DIVU   = 5'd19;
  localparam logic [4:0] ALU_REM    = 5'd20;
  localparam logic [4:0] ALU_REMU   = 5'd21;

  // FPU op codes; zero-extended to the configured FPUOp width at the point of use.
  localparam logic [2:0] FPU_FADD  = 3'd0;
  localparam logic [2:0] FPU_FSUB  = 3'd1;
  localparam logic [2:0] FPU_FMUL  = 3'd2;
  localparam logic [2:0] FPU_FDIV  = 3'd3;
  localparam logic [2:0] FPU_FSQRT = 3'd4;

  localparam logic [4:0] FPU_F7_FADD  = 5'b00000;
  localparam logic [4:0] FPU_F7_FSUB  = 5'b00001;
  localparam logic [4:0] FPU_F7_FMUL  = 5'b00010;
  localparam logic [4:0] FPU_F7_FDIV  = 5'b00011;
  localparam logic [4:0] FPU_F7_FSQRT = 5'b01011;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} seq_state_e;
  typedef enum logic [1:0] {LAT_ONE, LAT_MUL, LAT_DIV, LAT_FPU} lat_class_e;

  // Base integer op for funct7==0 register ops and for immediate ops.
  function automatic logic [4:0] base_alu_op(input logic [2:0] funct3);
    logic [4:0] op;
    case (funct3)
      FUNCT3_ADD:  op = ALU_ADD;
      FUNCT3_SLL:  op = ALU_SLL;
      FUNCT3_SLT:  op = ALU_SLT;
      FUNCT3_SLTU: op = ALU_SLTU;
      FUNCT3_XOR:  op = ALU_XOR;
      FUNCT3_SR:   op = ALU_SRL;
      FUNCT3_OR:   op = ALU_OR;
      default:     op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ex_op_decode.sv
// Combinational EX decode: ALUOp, FPUOp, CSR-immediate select and latency class.
// EX_DIVZERO_FAST_EN: divide/remainder by zero is classed as single-cycle.
module ex_op_decode
  import ex_op_sequencer_pkg::*;
#(
  parameter int FPU_OP_W = 3
) (
  input  logic [3:0]          EXcntrl,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                divisor_zero,
  output logic [4:0]          alu_op,
  output logic [FPU_OP_W-1:0] fpu_op,
  output logic                csr_imm,
  output lat_class_e          lat_class
);

  logic div_fast;

`ifdef EX_DIVZERO_FAST_EN
  assign div_fast = divisor_zero;
`else
  logic unused_divisor_zero;
  assign unused_divisor_zero = divisor_zero;
  assign div_fast = 1'b0;
`endif

  always_comb begin
    alu_op    = ALU_ADD;
    fpu_op    = '0;
    csr_imm   = 1'b0;
    lat_class = LAT_ONE;
    case (EXcntrl)
      EX_ALU_R: begin
        case (funct7)
          FUNCT7_BASE: alu_op = base_alu_op(funct3);
          FUNCT7_SUB: begin
            if (funct3 == FUNCT3_ADD)     alu_op = ALU_SUB;
            else if (funct3 == FUNCT3_SR) alu_op = ALU_SRA;
          end
          FUNCT7_MULDIV: begin
            case (funct3)
              3'b000:  alu_op = ALU_MUL;
              3'b001:  alu_op = ALU_MULH;
              3'b010:  alu_op = ALU_MULHSU;
              3'b011:  alu_op = ALU_MULHU;
              3'b100:  alu_op = ALU_DIV;
              3'b101:  alu_op = ALU_DIVU;
              3'b110:  alu_op = ALU_REM;
              default: alu_op = ALU_REMU;
            endcase
            // funct3[2] separates the divide/remainder group from multiplies
            if (!funct3[2])     lat_class = LAT_MUL;
            else if (!div_fast) lat_class = LAT_DIV;
          end
          default: alu_op = ALU_ADD;
        endcase
      end
      EX_ALU_I_COMP: begin
        if (funct3 == FUNCT3_SR) alu_op = (funct7 == FUNCT7_SUB) ? ALU_SRA : ALU_SRL;
        else                     alu_op = base_alu_op(funct3);
      end
      EX_BRANCH: begin
        alu_op = (funct3 == FUNCT3_BLTU || funct3 == FUNCT3_BGEU) ? ALU_SUBU : ALU_SUB;
      end
      EX_LUI:   alu_op = ALU_LUI;
      EX_AUIPC: alu_op = ALU_AUIPC;
      EX_CSR: begin
        case (funct3)
          FUNCT3_CSRRW:  alu_op = ALU_ADD;
          FUNCT3_CSRRS:  alu_op = ALU_OR;
          FUNCT3_CSRRC:  alu_op = ALU_CLEAR;
          FUNCT3_CSRRWI: begin alu_op = ALU_ADD;   csr_imm = 1'b1; end
          FUNCT3_CSRRSI: begin alu_op = ALU_OR;    csr_imm = 1'b1; end
          FUNCT3_CSRRCI: begin alu_op = ALU_CLEAR; csr_imm = 1'b1; end
          default:       alu_op = ALU_ADD;
        endcase
      end
      EX_FPU: begin
        lat_class = LAT_FPU;
        case (funct7[6:2])
          FPU_F7_FSUB:  fpu_op = FPU_OP_W'(FPU_FSUB);
          FPU_F7_FMUL:  fpu_op = FPU_OP_W'(FPU_FMUL);
          FPU_F7_FDIV:  fpu_op = FPU_OP_W'(FPU_FDIV);
          FPU_F7_FSQRT: fpu_op = FPU_OP_W'(FPU_FSQRT);
          default:      fpu_op = FPU_OP_W'(FPU_FADD);
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/ex_op_sequencer.sv
// EX-stage op sequencer: registers the decoded op and times its multi-cycle latency.
// EX_DIVZERO_FAST_EN (see ex_op_decode) shortens divide-by-zero to one cycle.
module ex_op_sequencer
  import ex_op_sequencer_pkg::*;
#(
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 33,
  parameter int FPU_LAT  = 4,
  parameter int FPU_OP_W = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          EXcntrl,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                divisor_zero,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4:0]          ALUOp,
  output logic [FPU_OP_W-1:0] FPUOp,
  output logic                csr_immidiate,
  output logic                stall
);

  seq_state_e          state_reg, state_next;
  logic [7:0]          cnt_reg, cnt_next;
  logic [4:0]          alu_reg;
  logic [FPU_OP_W-1:0] fpu_reg;
  logic                csr_reg;

  logic [4:0]          dec_alu;
  logic [FPU_OP_W-1:0] dec_fpu;
  logic                dec_csr;
  lat_class_e          dec_lat;
  logic [7:0]          lat_cycles;
  logic                accept;

  ex_op_decode #(.FPU_OP_W(FPU_OP_W)) u_decode (
    .EXcntrl      (EXcntrl),
    .funct3       (funct3),
    .funct7       (funct7),
    .divisor_zero (divisor_zero),
    .alu_op       (dec_alu),
    .fpu_op       (dec_fpu),
    .csr_imm      (dec_csr),
    .lat_class    (dec_lat)
  );

  always_comb begin
    case (dec_lat)
      LAT_MUL: lat_cycles = 8'(MUL_LAT);
      LAT_DIV: lat_cycles = 8'(DIV_LAT);
      LAT_FPU: lat_cycles = 8'(FPU_LAT);
      default: lat_cycles = 8'd1;
    endcase
  end

  assign in_ready      = (state_reg == ST_IDLE) || (state_reg == ST_DONE && out_ready);
  assign accept        = in_valid && in_ready && !flush;
  assign stall         = in_valid && !in_ready;
  assign out_valid     = (state_reg == ST_DONE);
  assign ALUOp         = alu_reg;
  assign FPUOp         = fpu_reg;
  assign csr_immidiate = csr_reg;

  // Accept is only possible from IDLE or DONE, so it shares one start path.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (flush) begin
      state_next = ST_IDLE;
      cnt_next   = 8'd0;
    end else if (accept) begin
      if (lat_cycles <= 8'd1) begin
        state_next = ST_DONE;
        cnt_next   = 8'd0;
      end else begin
        state_next = ST_BUSY;
        cnt_next   = lat_cycles - 8'd1;
      end
    end else begin
      case (state_reg)
        ST_BUSY: begin
          if (cnt_reg <= 8'd1) begin
            state_next = ST_DONE;
            cnt_next   = 8'd0;
          end else begin
            cnt_next = cnt_reg - 8'd1;
          end
        end
        ST_DONE: if (out_ready) state_next = ST_IDLE;
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alu_reg <= ALU_ADD;
      fpu_reg <= '0;
      csr_reg <= 1'b0;
    end else if (accept) begin
      alu_reg <= dec_alu;
      fpu_reg <= dec_fpu;
      csr_reg <= dec_csr;
    end
  end

endmodule

// File: tb/tb_ex_op_sequencer.sv
// Scoreboard bench for ex_op_sequencer: decode results and latency per accepted op.
module tb_ex_op_sequencer;
  import ex_op_sequencer_pkg::*;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 33;
  localparam int FPU_LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] EXcntrl = 4'd0;
  logic [2:0] funct3 = 3'd0;
  logic [6:0] funct7 = 7'd0;
  logic       divisor_zero = 1'b0;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [4:0] ALUOp;
  logic [2:0] FPUOp;
  logic       csr_immidiate;
  logic       stall;

  ex_op_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .FPU_LAT(FPU_LAT), .FPU_OP_W(3)) dut (
    .clock         (clk),
    .reset         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .EXcntrl       (EXcntrl),
    .funct3        (funct3),
    .funct7        (funct7),
    .divisor_zero  (divisor_zero),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .ALUOp         (ALUOp),
    .FPUOp         (FPUOp),
    .csr_immidiate (csr_immidiate),
    .stall         (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] alu;
    logic [2:0] fpu;
    logic       csr;
    int         lat;
    int         acc_cycle;
  } exp_t;

  typedef struct {
    logic [3:0] ex;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       dz;
  } stim_t;

  exp_t sb[$];
  exp_t pend;
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  bit   head_seen = 0;
  int   waits;

  logic [4:0] base_tab [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  logic [4:0] md_tab   [8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic exp_t model(input logic [3:0] ex, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic dz);
    exp_t e;
    e.alu = ALU_ADD; e.fpu = FPU_FADD; e.csr = 1'b0; e.lat = 1; e.acc_cycle = 0;
    if (ex == EX_ALU_R) begin
      if (f7 == 7'b0000001) begin
        e.alu = md_tab[f3];
        if (f3 < 3'd4) e.lat = MUL_LAT;
        else begin
`ifdef EX_DIVZERO_FAST_EN
          e.lat = dz ? 1 : DIV_LAT;
`else
          e.lat = DIV_LAT;
`endif
        end
      end else if (f7 == 7'b0000000) e.alu = base_tab[f3];
      else if (f7 == 7'b0100000) begin
        if (f3 == 3'd0) e.alu = ALU_SUB;
        if (f3 == 3'd5) e.alu = ALU_SRA;
      end
    end else if (ex == EX_ALU_I_COMP) begin
      if (f3 == 3'd5) e.alu = (f7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
      else e.alu = base_tab[f3];
    end else if (ex == EX_BRANCH) e.alu = (f3 >= 3'd6) ? ALU_SUBU : ALU_SUB;
    else if (ex == EX_LUI)   e.alu = ALU_LUI;
    else if (ex == EX_AUIPC) e.alu = ALU_AUIPC;
    else if (ex == EX_CSR) begin
      if (f3[1:0] == 2'd2) e.alu = ALU_OR;
      if (f3[1:0] == 2'd3) e.alu = ALU_CLEAR;
      e.csr = f3[2] && (f3[1:0] != 2'd0);
    end else if (ex == EX_FPU) begin
      e.lat = FPU_LAT;
      if (f7[6:2] == 5'b00001) e.fpu = FPU_FSUB;
      if (f7[6:2] == 5'b00010) e.fpu = FPU_FMUL;
      if (f7[6:2] == 5'b00011) e.fpu = FPU_FDIV;
      if (f7[6:2] == 5'b01011) e.fpu = FPU_FSQRT;
    end
    return e;
  endfunction

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: compares held outputs against the in-flight op and times out_valid.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      head_seen = 0;
    end else begin
      if (sb.size() > 0 && !flush) begin
        check_eq("alu_op", ALUOp, sb[0].alu);
        check_eq("fpu_op", FPUOp, sb[0].fpu);
        check_eq("csr_imm", csr_immidiate, sb[0].csr);
      end
      if (out_valid) begin
        if (sb.size() == 0) check_eq("spurious_out_valid", out_valid, 1'b0);
        else begin
          if (!head_seen) begin
            check_eq("latency", cycle - sb[0].acc_cycle, sb[0].lat);
            head_seen = 1;
          end
          if (out_ready && !flush) begin
            $display("txn alu=%0d fpu=%0d csr=%0d lat=%0d done@%0d",
                     sb[0].alu, sb[0].fpu, sb[0].csr, sb[0].lat, cycle);
            void'(sb.pop_front());
            head_seen = 0;
          end
        end
      end
      if (flush) begin
        sb.delete();
        head_seen = 0;
      end else if (in_valid && in_ready) begin
        mon_e = pend;
        mon_e.acc_cycle = cycle;
        sb.push_back(mon_e);
      end
    end
  end

  task automatic send(input logic [3:0] ex, input logic [2:0] f3, input logic [6:0] f7,
                      input logic dz, output int nwait);
    bit done;
    pend = model(ex, f3, f7, dz);
    EXcntrl = ex; funct3 = f3; funct7 = f7; divisor_zero = dz; in_valid = 1'b1;
    nwait = 0; done = 0;
    while (!done && nwait < 200) begin
      @(negedge clk);
      if (in_ready && !flush) done = 1;
      else begin
        check_eq("stall", stall, 1'b1);
        nwait++;
      end
    end
    if (!done) check_eq("accept_timeout", nwait, 0);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain_timeout", sb.size(), 0);
  endtask

  stim_t table_ops [] = '{
    '{EX_ALU_R, 3'b000, 7'b0100000, 1'b0}, '{EX_ALU_R, 3'b101, 7'b0100000, 1'b0},
    '{EX_ALU_R, 3'b100, 7'b0000000, 1'b0}, '{EX_ALU_R, 3'b011, 7'b0000000, 1'b0},
    '{EX_ALU_R, 3'b111, 7'b0000000, 1'b0}, '{EX_ALU_R, 3'b001, 7'b0100000, 1'b0},
    '{EX_ALU_I_COMP, 3'b101, 7'b0100000, 1'b0}, '{EX_ALU_I_COMP, 3'b101, 7'b0000000, 1'b0},
    '{EX_ALU_I_COMP, 3'b110, 7'b0000000, 1'b0}, '{EX_BRANCH, 3'b000, 7'b0, 1'b0},
    '{EX_BRANCH, 3'b110, 7'b0, 1'b0}, '{EX_BRANCH, 3'b111, 7'b0, 1'b0},
    '{EX_LUI, 3'b000, 7'b0, 1'b0}, '{EX_AUIPC, 3'b000, 7'b0, 1'b0},
    '{EX_LOAD_STORE, 3'b010, 7'b0, 1'b0}, '{EX_J, 3'b000, 7'b0, 1'b0},
    '{EX_CSR, 3'b001, 7'b0, 1'b0}, '{EX_CSR, 3'b010, 7'b0, 1'b0},
    '{EX_CSR, 3'b011, 7'b0, 1'b0}, '{EX_CSR, 3'b101, 7'b0, 1'b0},
    '{EX_CSR, 3'b110, 7'b0, 1'b0}, '{EX_CSR, 3'b111, 7'b0, 1'b0},
    '{EX_FPU, 3'b000, 7'b0000000, 1'b0}, '{EX_FPU, 3'b000, 7'b0000100, 1'b0},
    '{EX_FPU, 3'b000, 7'b0001100, 1'b0}, '{EX_FPU, 3'b000, 7'b0101100, 1'b0},
    '{EX_FPU, 3'b000, 7'b0010000, 1'b0}, '{EX_ALU_R, 3'b000, 7'b0000001, 1'b0},
    '{EX_ALU_R, 3'b001, 7'b0000001, 1'b0}, '{EX_ALU_R, 3'b010, 7'b0000001, 1'b0},
    '{EX_ALU_R, 3'b011, 7'b0000001, 1'b0}, '{EX_ALU_R, 3'b101, 7'b0000001, 1'b0},
    '{EX_ALU_R, 3'b110, 7'b0000001, 1'b0}, '{EX_ALU_R, 3'b111, 7'b0000001, 1'b0}
  };

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_alu_op", ALUOp, ALU_ADD);
    check_eq("rst_fpu_op", FPUOp, 3'd0);
    check_eq("rst_csr_imm", csr_immidiate, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back ADDs with out_ready held high
    out_ready = 1'b1;
    send(EX_ALU_R, 3'b000, 7'b0000000, 1'b0, waits);
    send(EX_ALU_R, 3'b000, 7'b0000000, 1'b0, waits);
    check_eq("b2b_wait", waits, 0);
    send(EX_ALU_R, 3'b010, 7'b0000000, 1'b0, waits);
    idle();
    drain();

    // DIV followed by a waiting ADD: stall throughout, DIV latency
    send(EX_ALU_R, 3'b100, 7'b0000001, 1'b0, waits);
    send(EX_ALU_R, 3'b000, 7'b0000000, 1'b0, waits);
    check_eq("div_stall_cycles", waits, DIV_LAT - 1);
    idle();
    drain();

    // FMUL with consumer back-pressure for 3 cycles
    out_ready = 1'b0;
    send(EX_FPU, 3'b000, 7'b0001000, 1'b0, waits);
    idle();
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check_eq("fmul_valid", out_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("hold_in_ready", in_ready, 1'b0);
      check_eq("hold_out_valid", out_valid, 1'b1);
      check_eq("hold_fpu_op", FPUOp, FPU_FMUL);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Flush a MUL in its last busy cycle
    send(EX_ALU_R, 3'b000, 7'b0000001, 1'b0, waits);
    idle();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_out_valid", out_valid, 1'b0);
    check_eq("flush_in_ready", in_ready, 1'b1);
    send(EX_ALU_R, 3'b100, 7'b0000000, 1'b0, waits);
    check_eq("flush_accept_wait", waits, 0);
    idle();
    drain();

    // Divide by zero
    send(EX_ALU_R, 3'b101, 7'b0000001, 1'b1, waits);
    idle();
    drain();

    // Decode table, issued back to back
    foreach (table_ops[i]) begin
      send(table_ops[i].ex, table_ops[i].f3, table_ops[i].f7, table_ops[i].dz, waits);
    end
    idle();
    drain();

    // Asynchronous reset in the middle of a DIV
    send(EX_ALU_R, 3'b110, 7'b0000001, 1'b0, waits);
    idle();
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", out_valid, 1'b0);
    check_eq("arst_alu_op", ALUOp, ALU_ADD);
    check_eq("arst_fpu_op", FPUOp, 3'd0);
    check_eq("arst_csr_imm", csr_immidiate, 1'b0);
    check_eq("arst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    send(EX_CSR, 3'b111, 7'b0, 1'b0, waits);
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
